instruction_fetch_mem: RTL and testbench
========================================

# instruction_fetch_mem

Parametrised instruction memory for the pipeline's IF stage, the successor to the fixed 16-bit combinational ROM. Programs are streamed in through a valid/ready load port after reset instead of being hard-coded. A registered, stall- and flush-aware fetch port then delivers one instruction per cycle. Addresses beyond the loaded program return a NOP and raise an error flag.

## Interface
Parameters:
- WORD_LEN, 16, instruction width in bits
- ADDRESS_LEN, 16, fetch address width
- MEMORY_SIZE, 256, depth in words; must satisfy MEMORY_SIZE <= 2^ADDRESS_LEN
- NOP_WORD, 16'b0, word driven on `inst` for bubbles, errors and reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- load_valid  in  1  loader presents a word
- load_data  in  WORD_LEN  word to store
- load_last  in  1  marks the final word of the program
- load_ready  out  1  memory accepts a word this cycle
- load_count  out  ADDRESS_LEN+1  number of words loaded
- running  out  1  load finished; fetch enabled
- fetch_en  in  1  request a fetch at `adr`
- stall  in  1  hold the current output
- flush  in  1  replace the current output with a bubble
- adr  in  ADDRESS_LEN  fetch word address
- inst  out  WORD_LEN  fetched instruction (registered)
- inst_valid  out  1  `inst` is a real instruction
- adr_err  out  1  last fetch address was >= load_count

## Operation
- Two-state FSM: LOAD (reset state) and RUN.
- **LOAD:**
  - load_ready = 1 while load_count < MEMORY_SIZE.
  - A handshake (load_valid & load_ready) writes mem[load_count] = load_data, then increments load_count.
  - A handshake with load_last = 1, or a handshake writing index MEMORY_SIZE-1, moves the FSM to RUN on the same edge.
  - Fetch inputs are ignored. Outputs stay at inst = NOP_WORD, inst_valid = 0, adr_err = 0.
- **RUN:**
  - load_ready = 0; load inputs are ignored.
  - running = 1. The FSM leaves RUN only on reset.
- **Fetch update per edge in RUN** (priority top-down):
  - flush = 1: inst = NOP_WORD, inst_valid = 0, adr_err = 0. Flush overrides stall.
  - stall = 1: inst, inst_valid and adr_err all hold.
  - fetch_en = 1 and adr < load_count: inst = mem[adr], inst_valid = 1, adr_err = 0.
  - fetch_en = 1 and adr >= load_count: inst = NOP_WORD, inst_valid = 0, adr_err = 1.
  - fetch_en = 0: inst holds; inst_valid = 0; adr_err = 0.
- Comparison width: adr is zero-extended to ADDRESS_LEN+1 before comparing with load_count.
- The memory array is not reset. Locations at or above load_count are never returned; the address gate above guarantees this.

## Timing
- Reset (asynchronous assert, any cycle):
  - FSM = LOAD, load_count = 0, running = 0, load_ready = 1.
  - inst = NOP_WORD, inst_valid = 0, adr_err = 0.
- Reset deassertion is synchronised externally; the first load handshake may occur on the first edge after release.
- Load throughput: one word per cycle.
- Load-to-run: running rises on the same edge as the accepted final write. The first fetch request is accepted on the following edge.
- Fetch latency: one cycle. adr and fetch_en sampled at edge N appear on inst/inst_valid after edge N.
- Stall hold lasts for the whole stall window. The first edge with stall = 0 samples the current adr and fetch_en.
- Simultaneous flush + stall + fetch_en: the flush result wins.
- Reset mid-load: load_count returns to 0. Previously written words become unreachable until they are rewritten.
- Full memory: after MEMORY_SIZE handshakes, the FSM is in RUN even without load_last.

## Test plan
- Reset then load 4 words (0xC511, 0x01F4, 0x8002, 0x11FE), load_last on the 4th -> load_count = 4, running rises on the 4th handshake edge, load_ready = 0 afterward.
- Fetch adr 0,1,2,3 back-to-back -> inst = 0xC511, 0x01F4, 0x8002, 0x11FE on consecutive cycles, each one cycle after request, inst_valid = 1.
- Fetch adr 1, then stall for 3 cycles while adr changes to 3 -> inst stays 0x01F4 with inst_valid = 1; first unstalled edge yields 0x11FE.
- Fetch adr 4 and adr 0xFFFF after a 4-word load -> inst = NOP_WORD, inst_valid = 0, adr_err = 1. Flush asserted with stall on the next cycle -> adr_err = 0, inst_valid = 0.
- Load MEMORY_SIZE = 8 words with load_last never asserted -> running after the 8th write. A 9th load_valid is not accepted; load_count = 8.
- Assert rst after 2 of 4 load words -> all outputs return to reset values immediately. Reload 1 word with load_last, then fetch adr 1 -> adr_err = 1.

Source files
------------

// File: rtl/instruction_fetch_mem.sv
// Instruction memory for the IF stage. A valid/ready port streams the program in after
// reset, and a registered fetch port then returns one instruction per cycle. The fetch
// port honours stall and flush. Addresses at or beyond the loaded length return a NOP
// and raise adr_err_o.
module instruction_fetch_mem #(
  parameter int unsigned         WORD_LEN    = 16,
  parameter int unsigned         ADDRESS_LEN = 16,
  parameter int unsigned         MEMORY_SIZE = 256,
  parameter logic [WORD_LEN-1:0] NOP_WORD    = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // Program load port
  input  logic                   load_valid_i,
  input  logic [WORD_LEN-1:0]    load_data_i,
  input  logic                   load_last_i,
  output logic                   load_ready_o,
  output logic [ADDRESS_LEN:0]   load_count_o,
  output logic                   running_o,
  // Fetch port
  input  logic                   fetch_en_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [ADDRESS_LEN-1:0] adr_i,
  output logic [WORD_LEN-1:0]    inst_o,
  output logic                   inst_valid_o,
  output logic                   adr_err_o
);

  localparam int unsigned CntW = ADDRESS_LEN + 1;
  localparam int unsigned IdxW = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [CntW-1:0] MemSize = CntW'(MEMORY_SIZE);
  localparam logic [CntW-1:0] MemLast = CntW'(MEMORY_SIZE - 1);

  typedef enum logic {StLoad, StRun} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       load_count_q, load_count_d;
  logic [WORD_LEN-1:0]   inst_q, inst_d;
  logic                  inst_valid_q, inst_valid_d;
  logic                  adr_err_q, adr_err_d;

  logic [WORD_LEN-1:0]   mem_q [MEMORY_SIZE];
  logic                  mem_we;
  logic                  load_hs;
  logic                  adr_in_range;
  logic [WORD_LEN-1:0]   rd_data;

  assign load_ready_o = (state_q == StLoad) && (load_count_q < MemSize);
  assign load_hs      = load_valid_i && load_ready_o;
  assign running_o    = (state_q == StRun);
  assign load_count_o = load_count_q;

  // Zero-extended compare; this gate is what keeps unloaded (stale) words unreachable.
  assign adr_in_range = {1'b0, adr_i} < load_count_q;
  assign rd_data      = mem_q[adr_i[IdxW-1:0]];

  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign adr_err_o    = adr_err_q;

  // Next-state: load sequencing in StLoad, prioritised fetch update in StRun.
  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    adr_err_d    = adr_err_q;
    mem_we       = 1'b0;
    unique case (state_q)
      StLoad: begin
        inst_d       = NOP_WORD;
        inst_valid_d = 1'b0;
        adr_err_d    = 1'b0;
        if (load_hs) begin
          mem_we       = 1'b1;
          load_count_d = load_count_q + CntW'(1);
          if (load_last_i || (load_count_q == MemLast)) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (flush_i) begin
          inst_d       = NOP_WORD;
          inst_valid_d = 1'b0;
          adr_err_d    = 1'b0;
        end else if (stall_i) begin
          // Hold everything.
        end else if (fetch_en_i) begin
          if (adr_in_range) begin
            inst_d       = rd_data;
            inst_valid_d = 1'b1;
            adr_err_d    = 1'b0;
          end else begin
            inst_d       = NOP_WORD;
            inst_valid_d = 1'b0;
            adr_err_d    = 1'b1;
          end
        end else begin
          // Idle cycle: keep the last word visible but mark it as not valid.
          inst_valid_d = 1'b0;
          adr_err_d    = 1'b0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // FSM state, load counter and registered fetch outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StLoad;
      load_count_q <= '0;
      inst_q       <= NOP_WORD;
      inst_valid_q <= 1'b0;
      adr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      adr_err_q    <= adr_err_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[load_count_q[IdxW-1:0]] <= load_data_i;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Bench for instruction_fetch_mem: table-driven fetch vectors, hand-written load/reset
// sequences, and a randomised fetch phase checked against a rule-level reference model.
module tb_instruction_fetch_mem;

  localparam int unsigned WL = 16;
  localparam int unsigned AL = 16;
  localparam int unsigned MS = 8;
  localparam logic [WL-1:0] NOP = 16'hE000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [WL-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic [AL:0]   load_count;
  logic          running;
  logic          fetch_en = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [AL-1:0] adr = '0;
  logic [WL-1:0] inst;
  logic          inst_valid;
  logic          adr_err;

  int n_vec = 0;
  int n_err = 0;

  instruction_fetch_mem #(
    .WORD_LEN   (WL),
    .ADDRESS_LEN(AL),
    .MEMORY_SIZE(MS),
    .NOP_WORD   (NOP)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_valid_i(load_valid),
    .load_data_i (load_data),
    .load_last_i (load_last),
    .load_ready_o(load_ready),
    .load_count_o(load_count),
    .running_o   (running),
    .fetch_en_i  (fetch_en),
    .stall_i     (stall),
    .flush_i     (flush),
    .adr_i       (adr),
    .inst_o      (inst),
    .inst_valid_o(inst_valid),
    .adr_err_o   (adr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string name, input logic [WL-1:0] ei, input logic ev,
                           input logic ee);
    chk({name, ".inst"}, 32'(inst), 32'(ei));
    chk({name, ".valid"}, 32'(inst_valid), 32'(ev));
    chk({name, ".err"}, 32'(adr_err), 32'(ee));
  endtask

  task automatic chk_reset_state(input string name);
    chk_fetch(name, NOP, 1'b0, 1'b0);
    chk({name, ".count"}, 32'(load_count), 32'd0);
    chk({name, ".running"}, 32'(running), 32'd0);
    chk({name, ".ready"}, 32'(load_ready), 32'd1);
  endtask

  task automatic load_word(input logic [WL-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic set_fetch(input logic f, input logic s, input logic fl, input logic [AL-1:0] a);
    fetch_en = f;
    stall    = s;
    flush    = fl;
    adr      = a;
  endtask

  // Table of fetch vectors applied after the 4-word program is loaded.
  typedef struct {
    logic          fen;
    logic          stl;
    logic          fls;
    logic [AL-1:0] a;
    logic [WL-1:0] e_inst;
    logic          e_valid;
    logic          e_err;
  } vec_t;

  // Reference model: a plain array and the fetch rules, one call per clock edge.
  logic [WL-1:0] m_mem [MS];
  int            m_count;
  logic [WL-1:0] m_inst;
  logic          m_valid;
  logic          m_err;

  task automatic model_edge(input logic f, input logic s, input logic fl, input logic [AL-1:0] a);
    if (fl) begin
      m_inst = NOP; m_valid = 1'b0; m_err = 1'b0;
    end else if (s) begin
      // hold
    end else if (f) begin
      if (int'(a) < m_count) begin
        m_inst = m_mem[int'(a)]; m_valid = 1'b1; m_err = 1'b0;
      end else begin
        m_inst = NOP; m_valid = 1'b0; m_err = 1'b1;
      end
    end else begin
      m_valid = 1'b0; m_err = 1'b0;
    end
  endtask

  initial begin
    vec_t          tbl[$];
    logic [WL-1:0] prog [4];
    logic          f, s, fl;
    logic [AL-1:0] a;

    prog[0] = 16'hC511; prog[1] = 16'h01F4; prog[2] = 16'h8002; prog[3] = 16'h11FE;

    tbl.push_back('{1'b1, 1'b0, 1'b0, 16'd0,    16'hC511, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 16'd1,    16'h01F4, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 16'd2,    16'h8002, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 16'd3,    16'h11FE, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 16'd1,    16'h01F4, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 16'd3,    16'h01F4, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 16'd3,    16'h01F4, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 16'd3,    16'h01F4, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 16'd3,    16'h11FE, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 16'd4,    NOP,      1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 16'hFFFF, NOP,      1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 16'd0,    NOP,      1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 16'd2,    16'h8002, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 16'd1,    16'h8002, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 16'd1,    16'h8002, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 16'd4,    NOP,      1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 16'd0,    NOP,      1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd0,    NOP,      1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 16'd0,    16'hC511, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 16'd1,    NOP,      1'b0, 1'b0});

    // Reset state.
    tick(); tick();
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Load 4 words; fetch requests during LOAD must be ignored.
    set_fetch(1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      load_word(prog[i], i == 3);
      chk($sformatf("load%0d.count", i), 32'(load_count), 32'(i + 1));
      chk($sformatf("load%0d.running", i), 32'(running), (i == 3) ? 32'd1 : 32'd0);
      chk_fetch($sformatf("load%0d", i), NOP, 1'b0, 1'b0);
    end
    chk("load.ready_after", 32'(load_ready), 32'd0);

    // Table vectors; load port is driven throughout and must be ignored.
    load_valid = 1'b1;
    load_data  = 16'h5A5A;
    foreach (tbl[i]) begin
      set_fetch(tbl[i].fen, tbl[i].stl, tbl[i].fls, tbl[i].a);
      tick();
      chk_fetch($sformatf("tbl%0d", i), tbl[i].e_inst, tbl[i].e_valid, tbl[i].e_err);
    end
    load_valid = 1'b0;
    chk("run.count_held", 32'(load_count), 32'd4);

    // Randomised fetch traffic against the reference model.
    for (int i = 0; i < 4; i++) m_mem[i] = prog[i];
    m_count = 4;
    m_inst  = NOP; m_valid = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 250; i++) begin
      f  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 7) == 0);
      a  = ($urandom_range(0, 7) == 0) ? AL'($urandom) : AL'($urandom_range(0, 5));
      set_fetch(f, s, fl, a);
      load_valid = 1'($urandom);
      tick();
      model_edge(f, s, fl, a);
      chk_fetch($sformatf("rnd%0d", i), m_inst, m_valid, m_err);
    end
    load_valid = 1'b0;

    // Asynchronous reset mid-cycle: outputs change before any clock edge.
    set_fetch(1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    tick();
    rst_n = 1'b1;

    // Reset after 2 of 4 words, then reload 1 word; old words must be unreachable.
    load_word(16'h1111, 1'b0);
    load_word(16'h2222, 1'b0);
    chk("partial.count", 32'(load_count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid_load_rst");
    tick();
    rst_n = 1'b1;
    load_word(16'hABCD, 1'b1);
    chk("reload.count", 32'(load_count), 32'd1);
    chk("reload.running", 32'(running), 32'd1);
    set_fetch(1'b1, 1'b0, 1'b0, 16'd1);
    tick();
    chk_fetch("reload.adr1", NOP, 1'b0, 1'b1);
    set_fetch(1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    chk_fetch("reload.adr0", 16'hABCD, 1'b1, 1'b0);

    // Fill all MS words without load_last.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < MS; i++) begin
      load_word(16'h3000 + WL'(i), 1'b0);
      chk($sformatf("full%0d.running", i), 32'(running), (i == MS - 1) ? 32'd1 : 32'd0);
    end
    chk("full.count", 32'(load_count), 32'(MS));
    chk("full.ready", 32'(load_ready), 32'd0);
    load_word(16'hFFFF, 1'b1);
    chk("full.extra_count", 32'(load_count), 32'(MS));
    set_fetch(1'b1, 1'b0, 1'b0, 16'(MS - 1));
    tick();
    chk_fetch("full.last", 16'h3000 + WL'(MS - 1), 1'b1, 1'b0);
    set_fetch(1'b1, 1'b0, 1'b0, 16'(MS));
    tick();
    chk_fetch("full.beyond", NOP, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
